// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_pkg.sv
// Shared definitions for the programmable inverting clock divider.
package gf180mcu_fd_sc_mcu9t5v0__clkdiv_pkg;

  localparam int unsigned DIV_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdivinv_cnt.sv
// Half-period counter: counts up to div_q, then wraps to zero and flags the wrap.
module gf180mcu_fd_sc_mcu9t5v0__clkdivinv_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         run,
  input  logic [W-1:0] div_q,
  output logic         wrap_c
);

  logic [W-1:0] cnt_q, cnt_d;

  // Equality compare means cnt never exceeds div_q, so it cannot overflow.
  assign wrap_c = (cnt_q == div_q);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = wrap_c ? '0 : W'(cnt_q + W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdivinv.sv
// Programmable clock divider with polarity select; ratio and polarity are
// only sampled at start-up and at each falling period boundary.
module gf180mcu_fd_sc_mcu9t5v0__clkdivinv
  import gf180mcu_fd_sc_mcu9t5v0__clkdiv_pkg::*;
#(
  parameter int unsigned W = DIV_W_DEF
) (
`ifdef USE_POWER_PINS
  inout  wire          VDD,
  inout  wire          VSS,
`endif
  input  logic         CLK,
  input  logic         RN,
  input  logic         EN,
  input  logic [W-1:0] DIV,
  input  logic         INV,
  output logic         Z,
  output logic         ZN,
  output logic         TC,
  output logic         BUSY
);

  state_e       state_q, state_d;
  logic         phase_q, phase_d;
  logic [W-1:0] div_q, div_d;
  logic         inv_q, inv_d;
  logic         tc_q, tc_d;
  logic         z_q, z_d;
  logic         zn_q, zn_d;
  logic         busy_q, busy_d;
  logic         cnt_clr, cnt_run, wrap_c;

  gf180mcu_fd_sc_mcu9t5v0__clkdivinv_cnt #(.W(W)) u_cnt (
    .clk    (CLK),
    .rst_n  (RN),
    .clr    (cnt_clr),
    .run    (cnt_run),
    .div_q  (div_q),
    .wrap_c (wrap_c)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    div_d   = div_q;
    inv_d   = inv_q;
    tc_d    = 1'b0;
    cnt_clr = 1'b0;
    cnt_run = 1'b0;
    case (state_q)
      IDLE: begin
        if (EN) begin
          div_d   = DIV;
          inv_d   = INV;
          phase_d = 1'b1;
          cnt_clr = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_run = 1'b1;
        if (wrap_c) begin
          phase_d = ~phase_q;
          // Falling edge of phase closes a period: EN here decides continue/stop.
          if (phase_q) begin
            tc_d = 1'b1;
            if (EN) begin
              div_d = DIV;
              inv_d = INV;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    z_d    = phase_d ^ inv_d;
    zn_d   = ~z_d;
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      div_q   <= '0;
      inv_q   <= 1'b0;
      tc_q    <= 1'b0;
      z_q     <= 1'b0;
      zn_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      inv_q   <= inv_d;
      tc_q    <= tc_d;
      z_q     <= z_d;
      zn_q    <= zn_d;
      busy_q  <= busy_d;
    end
  end

  assign Z    = z_q;
  assign ZN   = zn_q;
  assign TC   = tc_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__clkdivinv.sv
// Directed and random checks of the clock divider against a phase-countdown model.
module tb_gf180mcu_fd_sc_mcu9t5v0__clkdivinv;
  import gf180mcu_fd_sc_mcu9t5v0__clkdiv_pkg::*;

  logic       clk = 1'b0;
  logic       rn;
  logic       en8, inv8, en4, inv4;
  logic [7:0] div8;
  logic [3:0] div4;
  logic       z8, zn8, tc8, busy8;
  logic       z4, zn4, tc4, busy4;

  int tests = 0;
  int fails = 0;

  // Model: running flag, current half (hi), cycles still to go in this half.
  typedef struct packed {
    bit          run;
    bit          hi;
    bit          inv;
    bit          tc;
    int unsigned left;
    int unsigned div;
  } mdl_t;

  mdl_t m8, m4;

  gf180mcu_fd_sc_mcu9t5v0__clkdivinv #(.W(8)) dut8 (
    .CLK(clk), .RN(rn), .EN(en8), .DIV(div8), .INV(inv8),
    .Z(z8), .ZN(zn8), .TC(tc8), .BUSY(busy8)
  );

  gf180mcu_fd_sc_mcu9t5v0__clkdivinv #(.W(4)) dut4 (
    .CLK(clk), .RN(rn), .EN(en4), .DIV(div4), .INV(inv4),
    .Z(z4), .ZN(zn4), .TC(tc4), .BUSY(busy4)
  );

  always #5 clk = ~clk;

  function automatic mdl_t mstep(mdl_t m, bit en, int unsigned div, bit inv);
    mdl_t n = m;
    n.tc = 1'b0;
    if (!m.run) begin
      if (en) begin
        n.run = 1'b1; n.hi = 1'b1; n.div = div; n.inv = inv; n.left = div;
      end
    end else if (m.left != 0) begin
      n.left = m.left - 1;
    end else if (m.hi) begin
      n.tc = 1'b1;
      n.hi = 1'b0;
      if (en) begin
        n.div = div; n.inv = inv; n.left = div;
      end else begin
        n.run = 1'b0;
      end
    end else begin
      n.hi   = 1'b1;
      n.left = m.div;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("z8",    z8,    m8.hi ^ m8.inv);
    chk("zn8",   zn8,   ~(m8.hi ^ m8.inv));
    chk("tc8",   tc8,   m8.tc);
    chk("busy8", busy8, m8.run);
    chk("z4",    z4,    m4.hi ^ m4.inv);
    chk("zn4",   zn4,   ~(m4.hi ^ m4.inv));
    chk("tc4",   tc4,   m4.tc);
    chk("busy4", busy4, m4.run);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rn) begin
      m8 = '0;
      m4 = '0;
    end else begin
      m8 = mstep(m8, en8, 32'(div8), inv8);
      m4 = mstep(m4, en4, 32'(div4), inv4);
    end
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Cycles between two consecutive TC pulses of the chosen instance; -1 on timeout.
  task automatic tc_gap(input bit use4, input int limit, output int gap);
    bit seen = 1'b0;
    int t = 0;
    gap = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (seen) t++;
      if ((use4 ? tc4 : tc8) === 1'b1) begin
        if (seen) begin
          gap = t;
          break;
        end
        seen = 1'b1;
        t = 0;
      end
    end
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (!m8.run && !m4.run) break;
      tick();
    end
    chk_int(tag, (m8.run || m4.run) ? 1 : 0, 0);
  endtask

  initial begin
    int g;
    int h;
    int n;
    rn = 1'b0; en8 = 1'b0; div8 = 8'd0; inv8 = 1'b0;
    en4 = 1'b0; div4 = 4'd0; inv4 = 1'b0;
    m8 = '0; m4 = '0;
    ticks(3);
    chk("rst_z",    z8,    1'b0);
    chk("rst_zn",   zn8,   1'b1);
    chk("rst_tc",   tc8,   1'b0);
    chk("rst_busy", busy8, 1'b0);

    // Divide-by-8 on dut8 and divide-by-32 (full W=4 range) on dut4.
    rn = 1'b1;
    en8 = 1'b1; div8 = 8'd3; inv8 = 1'b0;
    en4 = 1'b1; div4 = 4'd15; inv4 = 1'b0;
    tc_gap(1'b0, 40, g);
    chk_int("period8", g, 8);

    // Ratio change two cycles into a high phase takes effect only at the next fall.
    for (int i = 0; i < 20; i++) begin
      if (m8.hi && m8.left == 1) break;
      tick();
    end
    div8 = 8'd1;
    tc_gap(1'b0, 40, g);
    chk_int("period_after_div", g, 4);
    ticks(4);

    tc_gap(1'b1, 100, g);
    chk_int("period4", g, 32);
    h = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (z4 === 1'b1) h++;
    end
    chk_int("high4", h, 16);

    en8 = 1'b0; en4 = 1'b0;
    wait_idle("stop_all", 100);
    ticks(2);

    // Divide-by-2 with inverted polarity.
    en8 = 1'b1; div8 = 8'd0; inv8 = 1'b1;
    tick();
    chk("d2_z_start",  z8,  1'b0);
    chk("d2_zn_start", zn8, 1'b1);
    ticks(9);
    chk("d2_busy", busy8, 1'b1);

    // Stop request one cycle after start still completes the period.
    en8 = 1'b0;
    wait_idle("idle_before_stop", 20);
    en8 = 1'b1; div8 = 8'd2; inv8 = 1'b0;
    tick();
    en8 = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (tc8 === 1'b1) n++;
    end
    chk_int("stop_tc_count", n, 1);
    chk("stop_busy", busy8, 1'b0);
    chk("stop_z",    z8,    1'b0);

    // Asynchronous reset mid-high-phase, then a clean restart.
    en8 = 1'b1; div8 = 8'd3; inv8 = 1'b0;
    ticks(3);
    #2 rn = 1'b0;
    #1;
    chk("arst_z",    z8,    1'b0);
    chk("arst_zn",   zn8,   1'b1);
    chk("arst_tc",   tc8,   1'b0);
    chk("arst_busy", busy8, 1'b0);
    m8 = '0; m4 = '0;
    tick();
    rn = 1'b1;
    h = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (z8 === 1'b1) h++;
    end
    chk_int("restart_high", h, 4);

    // Random traffic on both instances, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      en8  = ($urandom % 4) != 0;
      div8 = 8'($urandom % 6);
      inv8 = 1'($urandom % 2);
      en4  = ($urandom % 4) != 0;
      div4 = 4'($urandom % 16);
      inv4 = 1'($urandom % 2);
      rn   = ($urandom % 64) != 0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__clkdivinv.md
GF180MCU_FD_SC_MCU9T5V0__CLKDIVINV -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__clkdivinv

Interface
REQ-001 SHALL have parameter W, default 8: width of the divide-ratio input.
REQ-002 SHALL have port CLK  input  1  source clock; all state is updated on the rising edge only.
REQ-003 SHALL have port RN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port EN  input  1  run request; sampled on the CLK rising edge.
REQ-005 SHALL have port DIV  input  W  half-period minus one, so output period = 2*(DIV+1) CLK cycles.
REQ-006 SHALL have port INV  input  1  output polarity select; 1 inverts Z.
REQ-007 SHALL have port Z  output  1  divided clock, registered.
REQ-008 SHALL have port ZN  output  1  registered complement of Z.
REQ-009 SHALL have port TC  output  1  one-cycle pulse marking the end of each full output period.
REQ-010 SHALL have port BUSY  output  1  high while in state RUN.
REQ-011 SHALL provide power-pin ports VDD and VSS (inout) when USE_POWER_PINS is defined.

Function
REQ-012 SHALL hold internal registers: state {IDLE, RUN}, phase (1 bit), cnt (W bits), div_q (W bits), inv_q (1 bit).
REQ-013 SHALL drive Z = phase XOR inv_q and ZN = NOT Z, both taken directly from flops with no combinational path from any input.
REQ-014 In IDLE with EN=1 at an edge, SHALL load div_q<=DIV and inv_q<=INV, and SHALL set phase<=1, cnt<=0 and state<=RUN.
REQ-015 In IDLE with EN=0, SHALL keep all state, so Z = inv_q and BUSY = 0.
REQ-016 In RUN, SHALL increment cnt when cnt != div_q.
REQ-017 In RUN, when cnt == div_q, SHALL set cnt<=0 and toggle phase, so each phase lasts exactly div_q+1 cycles.
REQ-018 SHALL assert TC for exactly one cycle, registered, on the edge where phase goes 1->0.
REQ-019 At a 1->0 period boundary with EN=1, SHALL reload div_q<=DIV and inv_q<=INV, and SHALL stay in RUN.
REQ-020 At a 1->0 period boundary with EN=0, SHALL go to IDLE with phase=0, keeping inv_q.
REQ-021 SHALL ignore changes on DIV or INV except at IDLE->RUN entry and at 1->0 period boundaries; the high phase is never truncated.
REQ-022 SHALL ignore EN deassertion mid-period; the current period completes before the stop.
REQ-023 SHALL ignore EN reassertion during the final edge of a period, because that edge's EN value decides.
REQ-024 SHALL support DIV=0 as a divide-by-2 output (Z toggles every cycle).
REQ-025 SHALL support DIV=2^W-1 with half-period 2^W cycles, without cnt overflow.
REQ-026 An INV change loaded at a boundary SHALL take effect on that same edge, with no glitch; only the duty cycle of that one period may be affected.

Reset
REQ-027 RN low SHALL immediately force state=IDLE, phase=0, cnt=0, div_q=0, inv_q=0, so that Z=0, ZN=1, TC=0 and BUSY=0.
REQ-028 Reset mid-period SHALL abort the period without producing a TC pulse.
REQ-029 After RN rises, the first EN=1 edge SHALL start a new period per REQ-014.

Structure
REQ-030 SHALL take the state encoding (IDLE=0, RUN=1) from shared package gf180mcu_fd_sc_mcu9t5v0__clkdiv_pkg, which is also used by the bench.
REQ-031 SHALL place the cnt/div_q compare-and-wrap logic in one sub-module, gf180mcu_fd_sc_mcu9t5v0__clkdivinv_cnt, parameterised by W.
REQ-032 SHALL use no latches, no clock gating and no negedge flops.

Verification
REQ-033 Bench SHALL cover reset then EN=1, DIV=3, INV=0 -> Z high 4 cycles, low 4 cycles, repeating; TC pulses every 8 cycles, coincident with the Z fall.
REQ-034 Bench SHALL cover DIV=0, INV=1 -> ZN = divide-by-2 clock starting high; Z starting low; BUSY=1.
REQ-035 Bench SHALL cover DIV changed from 3 to 1 two cycles into a high phase -> the current period stays 8 cycles, and the next period is 4 cycles.
REQ-036 Bench SHALL cover EN dropped one cycle after a period starts, with DIV=2 -> the period completes (3 high, 3 low); state goes IDLE, Z=0, BUSY=0, with a single TC.
REQ-037 Bench SHALL cover RN pulsed low mid-high-phase -> Z=0, ZN=1 asynchronously; no TC; a restart with EN=1 produces a full first high phase.
REQ-038 Bench SHALL cover W=4, DIV=15 -> 16-cycle high phase, 32-cycle period, cnt wrapping 15->0 with no overflow.
